sysbus_mem_responder: RTL

Memory-side responder for the Sysbus request/response protocol used by the core's instruction fetch path. It accepts one line-sized request at a time. For a read it returns a 64-byte cache line as eight 64-bit response beats. For a write it absorbs eight 64-bit data beats into an internal line-organised backing store. It sits on the far end of the bus from the core and serves as the simulation memory model and as the reference responder for bus verification.

---
 rtl/sysbus_mem_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: serves line reads as eight 64-bit beats and
// absorbs eight-beat line writes into a line-organised backing store.
module sysbus_mem_responder #(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4,
    parameter int TAG_W       = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqcyc,
    input  logic [63:0]      req,
    input  logic [TAG_W-1:0] reqtag,
    output logic             reqack,
    output logic             respcyc,
    output logic [63:0]      resp,
    output logic [TAG_W-1:0] resptag,
    input  logic             respack
);

    localparam int LINE_W = $clog2(DEPTH_LINES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_WAIT  = 2'd1;
    localparam logic [1:0] S_RD_BURST = 2'd2;
    localparam logic [1:0] S_WR_DATA  = 2'd3;

    logic [1:0]        r_state;
    logic [LINE_W-1:0] r_line;
    logic [TAG_W-1:0]  r_tag;
    logic [2:0]        r_k;
    logic [3:0]        r_cnt;
    logic              r_reqack;
    logic              r_respcyc;
    logic [63:0]       r_resp;

    logic [63:0]       r_mem [DEPTH_LINES*8];

    logic              w_accept;
    logic              w_wr_beat;
    logic              w_beat_ack;
    logic [2:0]        w_rd_k;
    logic [LINE_W-1:0] w_req_line;
    logic [LINE_W+2:0] w_rd_addr;
    logic [LINE_W+2:0] w_wr_addr;
    logic              w_unused_req_bits;

    // The reqack cycle of a write is never a data beat, even if reqcyc trails high.
    assign w_accept   = (r_state == S_IDLE) && reqcyc;
    assign w_wr_beat  = (r_state == S_WR_DATA) && !r_reqack && reqcyc;
    assign w_beat_ack = r_respcyc && respack;

    assign w_req_line = req[6 +: LINE_W];
    assign w_rd_k     = (r_state == S_RD_WAIT) ? 3'd0 : r_k + 3'd1;
    assign w_rd_addr  = {r_line, w_rd_k};
    assign w_wr_addr  = {r_line, r_k};

    // Offset bits and address bits above the store size alias by design.
    assign w_unused_req_bits = ^{req[63:6+LINE_W], req[5:0]};

    assign reqack  = r_reqack || w_wr_beat;
    assign respcyc = r_respcyc;
    assign resp    = r_resp;
    assign resptag = r_tag;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_line    <= '0;
            r_tag     <= '0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_reqack  <= 1'b0;
            r_respcyc <= 1'b0;
            r_resp    <= '0;
        end else begin
            r_reqack <= w_accept;
            case (r_state)
                S_IDLE: begin
                    if (reqcyc) begin
                        r_line <= w_req_line;
                        r_tag  <= reqtag;
                        r_k    <= '0;
                        if (reqtag[TAG_W-1]) begin
                            r_state <= S_RD_WAIT;
                            r_cnt   <= 4'(LATENCY - 1);
                        end else begin
                            r_state <= S_WR_DATA;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= S_RD_BURST;
                        r_respcyc <= 1'b1;
                        r_resp    <= r_mem[w_rd_addr];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RD_BURST: begin
                    if (w_beat_ack) begin
                        if (r_k == 3'd7) begin
                            r_state   <= S_IDLE;
                            r_respcyc <= 1'b0;
                            r_k       <= '0;
                        end else begin
                            r_k    <= r_k + 3'd1;
                            r_resp <= r_mem[w_rd_addr];
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_wr_beat) begin
                        r_k <= r_k + 3'd1;
                        if (r_k == 3'd7) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the backing store has no reset so a partial write survives a
    // reset; the write strobe is already quiet while reset holds the FSM idle.
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            r_mem[w_wr_addr] <= req;
        end
    end

    a_no_ack_during_resp: assert property (
        @(posedge clk) disable iff (!reset) !(reqack && respcyc));

    a_hold_under_backpressure: assert property (
        @(posedge clk) disable iff (!reset)
        (respcyc && !respack) |=> (respcyc && $stable(resp) && $stable(resptag)));

endmodule
